axil_reg_slave: RTL and testbench

- AXI4-Lite responder holding the accelerator's memory-mapped control registers.
- Sits between the host interconnect and the top-level command decoder.
- Drives the flattened register image, write index and one-cycle write-commit pulse to the decoder.
- Returns either stored register contents or decoder-supplied status words on reads.

---
 rtl/axil_reg_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
// axil_reg_slave: AXI4-Lite control-register responder feeding the command decoder.
// Rev 1.0 -- define AXIL_WSTRB_EN to honour write byte strobes (default: full-word writes).
// ============================================================================
module axil_reg_slave #(
  parameter int                      AXIL_DATA_WIDTH = 64,
  parameter int                      AXIL_ADDR_WIDTH = 32,
  parameter int                      NUM_REGISTER    = 6,
  parameter logic [NUM_REGISTER-1:0] RO_MASK         = 6'b100000
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [AXIL_ADDR_WIDTH-1:0]              s_axil_awaddr,
  input  logic                                    s_axil_awvalid,
  output logic                                    s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0]              s_axil_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0]            s_axil_wstrb,
  input  logic                                    s_axil_wvalid,
  output logic                                    s_axil_wready,
  output logic [1:0]                              s_axil_bresp,
  output logic                                    s_axil_bvalid,
  input  logic                                    s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]              s_axil_araddr,
  input  logic                                    s_axil_arvalid,
  output logic                                    s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0]              s_axil_rdata,
  output logic [1:0]                              s_axil_rresp,
  output logic                                    s_axil_rvalid,
  input  logic                                    s_axil_rready,
  output logic [AXIL_DATA_WIDTH*NUM_REGISTER-1:0] slv_reg_down,
  input  logic [AXIL_DATA_WIDTH*NUM_REGISTER-1:0] slv_reg_up,
  output logic [$clog2(NUM_REGISTER)-1:0]         access_addr,
  output logic                                    write_valid
);

  localparam int               IDX_W       = $clog2(NUM_REGISTER);
  localparam logic [IDX_W:0]   IDX_LIMIT   = (IDX_W+1)'(NUM_REGISTER);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_COMMIT = 2'd1, WR_RESP = 2'd2} wr_state_e;
  typedef enum logic       {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

  wr_state_e                  wr_state_q;
  rd_state_e                  rd_state_q;
  logic                       aw_held_q, w_held_q;
  logic [IDX_W-1:0]           wr_idx_q;
  logic [AXIL_DATA_WIDTH-1:0] wr_data_q;
`ifdef AXIL_WSTRB_EN
  logic [AXIL_DATA_WIDTH/8-1:0] wr_strb_q;
`endif
  logic [AXIL_DATA_WIDTH-1:0] reg_q [NUM_REGISTER];
  logic                       awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]                 bresp_q, rresp_q;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]           access_addr_q;
  logic                       write_valid_q;

  logic                       aw_fire, w_fire, ar_fire;
  logic                       aw_held_d, w_held_d;
  logic [IDX_W-1:0]           ar_idx;
  logic                       wr_in_range, ar_in_range;
  logic [AXIL_DATA_WIDTH-1:0] wr_word_d, rd_word_d;
  logic                       unused_ok;

  assign aw_fire     = s_axil_awvalid & awready_q;
  assign w_fire      = s_axil_wvalid & wready_q;
  assign ar_fire     = s_axil_arvalid & arready_q;
  assign aw_held_d   = aw_held_q | aw_fire;
  assign w_held_d    = w_held_q | w_fire;
  assign ar_idx      = s_axil_araddr[3 +: IDX_W];
  assign wr_in_range = {1'b0, wr_idx_q} < IDX_LIMIT;
  assign ar_in_range = {1'b0, ar_idx} < IDX_LIMIT;

  always_comb begin
    rd_word_d = '0;
    for (int i = 0; i < NUM_REGISTER; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_word_d = RO_MASK[i] ? slv_reg_up[i*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH] : reg_q[i];
      end
    end
`ifdef AXIL_WSTRB_EN
    wr_word_d = '0;
    for (int i = 0; i < NUM_REGISTER; i++) begin
      if (wr_idx_q == IDX_W'(i)) wr_word_d = reg_q[i];
    end
    for (int k = 0; k < AXIL_DATA_WIDTH/8; k++) begin
      if (wr_strb_q[k]) wr_word_d[k*8 +: 8] = wr_data_q[k*8 +: 8];
    end
`else
    wr_word_d = wr_data_q;
`endif
  end

  // Storage, write_valid and access_addr all change on the edge leaving WR_COMMIT,
  // so the decoder sees the new image in the same cycle as the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q    <= WR_IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      wr_idx_q      <= '0;
      wr_data_q     <= '0;
`ifdef AXIL_WSTRB_EN
      wr_strb_q     <= '0;
`endif
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      write_valid_q <= 1'b0;
      access_addr_q <= '0;
      for (int i = 0; i < NUM_REGISTER; i++) reg_q[i] <= '0;
    end else begin
      write_valid_q <= 1'b0;
      case (wr_state_q)
        WR_IDLE: begin
          if (aw_fire) wr_idx_q <= s_axil_awaddr[3 +: IDX_W];
          if (w_fire) begin
            wr_data_q <= s_axil_wdata;
`ifdef AXIL_WSTRB_EN
            wr_strb_q <= s_axil_wstrb;
`endif
          end
          if (aw_held_d && w_held_d) begin
            wr_state_q <= WR_COMMIT;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
          end else begin
            awready_q  <= ~aw_held_d;
            wready_q   <= ~w_held_d;
          end
          aw_held_q <= aw_held_d;
          w_held_q  <= w_held_d;
        end
        WR_COMMIT: begin
          aw_held_q  <= 1'b0;
          w_held_q   <= 1'b0;
          bvalid_q   <= 1'b1;
          wr_state_q <= WR_RESP;
          if (wr_in_range) begin
            for (int i = 0; i < NUM_REGISTER; i++) begin
              if (wr_idx_q == IDX_W'(i)) reg_q[i] <= wr_word_d;
            end
            write_valid_q <= 1'b1;
            access_addr_q <= wr_idx_q;
            bresp_q       <= RESP_OKAY;
          end else begin
            bresp_q       <= RESP_SLVERR;
          end
        end
        WR_RESP: begin
          if (s_axil_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_fire) begin
            rdata_q    <= rd_word_d;
            rresp_q    <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= RD_DATA;
          end else begin
            arready_q  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axil_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGISTER; g++) begin : g_flat
    assign slv_reg_down[g*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH] = reg_q[g];
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign access_addr    = access_addr_q;
  assign write_valid    = write_valid_q;

`ifdef AXIL_WSTRB_EN
  assign unused_ok = ^{s_axil_awaddr, s_axil_araddr};
`else
  assign unused_ok = ^{s_axil_awaddr, s_axil_araddr, s_axil_wstrb};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// tb_axil_reg_slave: directed plus randomized traffic checked every cycle against a transaction-level model.
module tb_axil_reg_slave;

  localparam logic [5:0] RO = 6'b100000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  s_axil_awaddr, s_axil_araddr;
  logic         s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [63:0]  s_axil_wdata, s_axil_rdata;
  logic [7:0]   s_axil_wstrb;
  logic [1:0]   s_axil_bresp, s_axil_rresp;
  logic         s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic         s_axil_rvalid, s_axil_rready;
  logic [383:0] slv_reg_down, slv_reg_up;
  logic [2:0]   access_addr;
  logic         write_valid;

  axil_reg_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready), .slv_reg_down(slv_reg_down),
    .slv_reg_up(slv_reg_up), .access_addr(access_addr), .write_valid(write_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int wv_cnt  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_total++;
    n_bad++;
    $display("FAIL %s: got timeout expected handshake (t=%0t)", nm, $time);
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] st);
`ifdef AXIL_WSTRB_EN
    merge = old;
    for (int k = 0; k < 8; k++) if (st[k]) merge[k*8 +: 8] = nw[k*8 +: 8];
`else
    merge = nw;
`endif
  endfunction

  // ---------------- transaction-level model ----------------
  logic [63:0] m_reg [6];
  logic        m_awready = 0, m_wready = 0, m_arready = 0, m_bvalid = 0, m_rvalid = 0, m_wv = 0;
  logic [1:0]  m_bresp = 0, m_rresp = 0;
  logic [63:0] m_rdata = 0, m_w_data = 0, m_c_data = 0;
  logic [7:0]  m_w_strb = 0, m_c_strb = 0;
  logic [2:0]  m_aa = 0;
  bit          m_aw_held = 0, m_w_held = 0, m_commit = 0;
  bit          h_aw, h_w, h_ar, h_b, h_r;
  int          m_aw_idx = 0, m_c_idx = 0, m_ri = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) m_reg[i] = '0;
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0; m_wv = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0; m_aa = 0;
      m_aw_held = 0; m_w_held = 0; m_commit = 0;
    end else begin
      h_aw = s_axil_awvalid && m_awready;
      h_w  = s_axil_wvalid && m_wready;
      h_ar = s_axil_arvalid && m_arready;
      h_b  = m_bvalid && s_axil_bready;
      h_r  = m_rvalid && s_axil_rready;
      m_wv = 0;
      if (h_r) m_rvalid = 0;
      // reads see storage as it was before any commit on this same edge
      if (h_ar) begin
        m_ri = int'((s_axil_araddr / 8) % 8);
        m_rvalid = 1;
        if (m_ri < 6) begin
          m_rdata = RO[m_ri] ? slv_reg_up[m_ri*64 +: 64] : m_reg[m_ri];
          m_rresp = 2'b00;
        end else begin
          m_rdata = '0;
          m_rresp = 2'b10;
        end
      end
      if (h_b) m_bvalid = 0;
      if (m_commit) begin
        m_commit = 0;
        m_bvalid = 1;
        if (m_c_idx < 6) begin
          m_reg[m_c_idx] = merge(m_reg[m_c_idx], m_c_data, m_c_strb);
          m_wv = 1; m_aa = m_c_idx[2:0]; m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
      end
      if (h_aw) begin m_aw_held = 1; m_aw_idx = int'((s_axil_awaddr / 8) % 8); end
      if (h_w)  begin m_w_held = 1; m_w_data = s_axil_wdata; m_w_strb = s_axil_wstrb; end
      if (m_aw_held && m_w_held) begin
        m_commit = 1; m_c_idx = m_aw_idx; m_c_data = m_w_data; m_c_strb = m_w_strb;
        m_aw_held = 0; m_w_held = 0;
      end
      m_awready = !m_commit && !m_bvalid && !m_aw_held;
      m_wready  = !m_commit && !m_bvalid && !m_w_held;
      m_arready = !m_rvalid;
    end
  end

  function automatic logic [383:0] m_img();
    for (int i = 0; i < 6; i++) m_img[i*64 +: 64] = m_reg[i];
  endfunction

  always @(negedge clk) begin
    if (write_valid === 1'b1) wv_cnt++;
    if (chk_en) begin
      chk("awready", s_axil_awready, m_awready);
      chk("wready", s_axil_wready, m_wready);
      chk("arready", s_axil_arready, m_arready);
      chk("bvalid", s_axil_bvalid, m_bvalid);
      if (m_bvalid) chk("bresp", s_axil_bresp, m_bresp);
      chk("write_valid", write_valid, m_wv);
      chk("access_addr", access_addr, m_aa);
      chk("slv_reg_down", slv_reg_down, m_img());
      chk("rvalid", s_axil_rvalid, m_rvalid);
      if (m_rvalid) begin
        chk("rdata", s_axil_rdata, m_rdata);
        chk("rresp", s_axil_rresp, m_rresp);
      end
    end
  end

  // ---------------- drivers (always entered and left at a negedge) ----------------
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int awd, input int wd, input int bd,
                          output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0; resp = 2'bxx; lat = -1;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    while (!(aw_done && w_done) && n < 40) begin
      s_axil_awvalid = !aw_done && (n >= awd);
      s_axil_wvalid  = !w_done && (n >= wd);
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(negedge clk);
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      n++;
    end
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    if (!(aw_done && w_done)) begin timeout("wr_accept"); return; end
    lat = 1; n = 0;
    while (!s_axil_bvalid && n < 20) begin @(negedge clk); lat++; n++; end
    if (!s_axil_bvalid) begin timeout("wr_bvalid"); return; end
    repeat (bd) @(negedge clk);
    s_axil_bready = 1;
    resp = s_axil_bresp;
    @(negedge clk);
    s_axil_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int ard, input int rd,
                         output logic [63:0] data, output logic [1:0] resp);
    bit done, hs;
    int n;
    done = 0; n = 0; data = 'x; resp = 2'bxx;
    s_axil_araddr = a;
    while (!done && n < 40) begin
      s_axil_arvalid = (n >= ard);
      hs = s_axil_arvalid && s_axil_arready;
      @(negedge clk);
      done = hs;
      n++;
    end
    s_axil_arvalid = 0;
    if (!done) begin timeout("rd_accept"); return; end
    n = 0;
    while (!s_axil_rvalid && n < 20) begin @(negedge clk); n++; end
    if (!s_axil_rvalid) begin timeout("rd_rvalid"); return; end
    repeat (rd) @(negedge clk);
    s_axil_rready = 1;
    data = s_axil_rdata;
    resp = s_axil_rresp;
    @(negedge clk);
    s_axil_rready = 0;
  endtask

  // ---------------- sequence ----------------
  logic [1:0]   resp, resp2, rresp_v;
  logic [63:0]  rdat;
  logic [383:0] img;
  int           lat, lat2, base, wi, ri, n;
  logic [31:0]  wa, ra;

  initial begin
    s_axil_awaddr = 0; s_axil_awvalid = 0; s_axil_wdata = 0; s_axil_wstrb = 0; s_axil_wvalid = 0;
    s_axil_bready = 0; s_axil_araddr = 0; s_axil_arvalid = 0; s_axil_rready = 0; slv_reg_up = '0;
    repeat (3) @(negedge clk);
    chk("rst_awready", s_axil_awready, 0);
    chk("rst_wready", s_axil_wready, 0);
    chk("rst_arready", s_axil_arready, 0);
    chk("rst_bvalid", s_axil_bvalid, 0);
    chk("rst_rvalid", s_axil_rvalid, 0);
    chk("rst_bresp", s_axil_bresp, 0);
    chk("rst_rresp", s_axil_rresp, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_slv_reg_down", slv_reg_down, 0);
    chk("rst_access_addr", access_addr, 0);
    chk("rst_write_valid", write_valid, 0);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);

    // same-cycle AW+W
    base = wv_cnt;
    do_write(32'h08, 64'h0000_1000_0000_0400, 8'hFF, 0, 0, 0, resp, lat);
    chk("t1_bresp", resp, 2'b00);
    chk("t1_latency", lat, 2);
    chk("t1_reg1", slv_reg_down[127:64], 64'h0000_1000_0000_0400);
    chk("t1_access_addr", access_addr, 3'd1);
    chk("t1_wv_pulses", wv_cnt - base, 1);

    // W leads AW by 3 cycles, bready held off 4 cycles
    base = wv_cnt;
    do_write(32'h00, 64'd2, 8'hFF, 3, 0, 4, resp, lat);
    chk("t2_bresp", resp, 2'b00);
    chk("t2_latency", lat, 2);
    chk("t2_reg0", slv_reg_down[63:0], 64'd2);
    chk("t2_access_addr", access_addr, 3'd0);
    chk("t2_wv_pulses", wv_cnt - base, 1);

    // register 5 reads back decoder status, register 3 reads back storage
    slv_reg_up[383:320] = 64'd1;
    do_write(32'h28, 64'hFFFF, 8'hFF, 0, 1, 0, resp, lat);
    chk("t3_reg5_stored", slv_reg_down[383:320], 64'hFFFF);
    do_read(32'h28, 0, 0, rdat, rresp_v);
    chk("t3_rd5_data", rdat, 64'd1);
    chk("t3_rd5_resp", rresp_v, 2'b00);
    do_write(32'h18, 64'h3F, 8'hFF, 1, 0, 0, resp, lat);
    do_read(32'h18, 0, 2, rdat, rresp_v);
    chk("t3_rd3_data", rdat, 64'h3F);

    // out-of-range index 6
    img = slv_reg_down;
    base = wv_cnt;
    do_write(32'h30, 64'hDEAD_BEEF_0000_1111, 8'hFF, 0, 0, 0, resp, lat);
    chk("t4_bresp", resp, 2'b10);
    chk("t4_wv_pulses", wv_cnt - base, 0);
    chk("t4_unchanged", slv_reg_down, img);
    do_read(32'h30, 0, 0, rdat, rresp_v);
    chk("t4_rd_data", rdat, 64'd0);
    chk("t4_rd_resp", rresp_v, 2'b10);

    // byte strobes
    do_write(32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0, resp, lat);
    do_write(32'h18, 64'h0, 8'h0F, 0, 0, 0, resp, lat);
`ifdef AXIL_WSTRB_EN
    chk("t5_strb_low", slv_reg_down[255:192], 64'hFFFF_FFFF_0000_0000);
`else
    chk("t5_strb_low", slv_reg_down[255:192], 64'h0);
`endif
    base = wv_cnt;
    do_write(32'h18, 64'h1234, 8'h00, 0, 0, 0, resp, lat);
    chk("t5_zero_strb_wv", wv_cnt - base, 1);
`ifdef AXIL_WSTRB_EN
    chk("t5_zero_strb", slv_reg_down[255:192], 64'hFFFF_FFFF_0000_0000);
`else
    chk("t5_zero_strb", slv_reg_down[255:192], 64'h1234);
`endif

    // read accepted on the same edge the write commits
    do_write(32'h10, 64'h11, 8'hFF, 0, 0, 0, resp, lat);
    fork
      do_write(32'h10, 64'h22, 8'hFF, 0, 0, 0, resp, lat);
      do_read(32'h10, 1, 0, rdat, rresp_v);
    join
    chk("t6_rd_old", rdat, 64'h11);
    chk("t6_reg2_new", slv_reg_down[191:128], 64'h22);

    // reset while bvalid is pending
    s_axil_awaddr = 32'h20; s_axil_wdata = 64'h5555; s_axil_wstrb = 8'hFF;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    @(negedge clk);
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    n = 0;
    while (!s_axil_bvalid && n < 10) begin @(negedge clk); n++; end
    chk("t7_bvalid_pending", s_axil_bvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("t7_bvalid_rst", s_axil_bvalid, 0);
    chk("t7_reg_rst", slv_reg_down, 0);
    @(negedge clk); rst_n = 1; @(negedge clk);

    // reset while rvalid is pending
    s_axil_araddr = 32'h28; s_axil_arvalid = 1;
    @(negedge clk);
    s_axil_arvalid = 0;
    n = 0;
    while (!s_axil_rvalid && n < 10) begin @(negedge clk); n++; end
    chk("t7_rvalid_pending", s_axil_rvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("t7_rvalid_rst", s_axil_rvalid, 0);
    chk("t7_arready_rst", s_axil_arready, 0);
    @(negedge clk); rst_n = 1; @(negedge clk);
    base = wv_cnt;
    do_write(32'h20, 64'hABCD, 8'hFF, 0, 0, 0, resp, lat);
    chk("t7_after_bresp", resp, 2'b00);
    chk("t7_after_reg4", slv_reg_down[319:256], 64'hABCD);
    chk("t7_after_wv", wv_cnt - base, 1);

    // randomized concurrent traffic
    for (int it = 0; it < 200; it++) begin
      for (int r = 0; r < 6; r++) slv_reg_up[r*64 +: 64] = {$urandom, $urandom};
      wi = int'($urandom_range(0, 7));
      ri = ($urandom_range(0, 1) == 1) ? wi : int'($urandom_range(0, 7));
      wa = ($urandom & 32'hFFFF_FFC7) | (32'(wi) << 3);
      ra = ($urandom & 32'hFFFF_FFC7) | (32'(ri) << 3);
      fork
        do_write(wa, {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp2, lat2);
        do_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rdat, rresp_v);
      join
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
